// File: rtl/mem_arb.sv
// Arbitrates fetch and load/store ports onto one single-port synchronous RAM with 1-cycle read latency.
// Optional macro MEM_ARB_RR_EN: round-robin on contested cycles; undefined gives fixed data-over-fetch priority.
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall
);

    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D, RESP_DERR} resp_e;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    resp_e      resp_q, resp_d;
    logic       d_load_q, d_load_d;
    logic       fetch_wins;
    logic       misaligned;
    logic       d_access;
    logic       d_store;
    logic [3:0] lane_base;

`ifdef MEM_ARB_RR_EN
    // rr_fetch_q = 1 means fetch wins the next contested cycle; only contested cycles move it.
    logic rr_fetch_q;

    assign fetch_wins = ~d_req | rr_fetch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_fetch_q <= 1'b1;
        end else if (if_req && d_req) begin
            rr_fetch_q <= ~rr_fetch_q;
        end
    end
`else
    assign fetch_wins = ~d_req;
`endif

    assign if_gnt = rst & if_req & fetch_wins;
    assign d_gnt  = rst & d_req & ~if_gnt;
    assign stall  = rst & d_req & ~d_gnt;

    always_comb begin
        misaligned = 1'b0;
        lane_base  = 4'b1111;
        case (d_size)
            2'b00: begin
                misaligned = 1'b0;
                lane_base  = 4'b0001;
            end
            2'b01: begin
                misaligned = d_addr[0];
                lane_base  = 4'b0011;
            end
            2'b10: begin
                misaligned = (d_addr[1:0] != 2'b00);
                lane_base  = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
                lane_base  = 4'b0000;
            end
        endcase
    end

    // Misaligned data accesses still take the grant but never reach the RAM.
    assign d_access = d_gnt & ~misaligned;
    assign d_store  = d_access & d_we;
    assign ram_en   = if_gnt | d_access;
    assign ram_we   = d_store ? (lane_base << d_addr[1:0]) : 4'b0000;

    always_comb begin
        ram_addr = '0;
        if (if_gnt) begin
            ram_addr = if_addr & WORD_MASK;
        end else if (d_access) begin
            ram_addr = d_addr & WORD_MASK;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_data;
            always_comb begin
                case (d_size)
                    2'b00:   lane_data = d_wdata[7:0];
                    2'b01:   lane_data = d_wdata[8*(gi%2) +: 8];
                    default: lane_data = d_wdata[8*gi +: 8];
                endcase
            end
            assign ram_wdata[8*gi +: 8] = d_store ? lane_data : 8'h00;
        end
    endgenerate

    always_comb begin
        resp_d   = IDLE;
        d_load_d = d_gnt & ~d_we;
        if (if_gnt) begin
            resp_d = RESP_IF;
        end else if (d_gnt && misaligned) begin
            resp_d = RESP_DERR;
        end else if (d_gnt) begin
            resp_d = RESP_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_q   <= IDLE;
            d_load_q <= 1'b0;
        end else begin
            resp_q   <= resp_d;
            d_load_q <= d_load_d;
        end
    end

    assign if_rvalid = (resp_q == RESP_IF);
    assign if_rdata  = if_rvalid ? ram_rdata : '0;
    assign d_rvalid  = (resp_q == RESP_D) || (resp_q == RESP_DERR);
    assign d_err     = (resp_q == RESP_DERR);
    assign d_rdata   = ((resp_q == RESP_D) && d_load_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        stall;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } d_exp_t;

    logic [31:0] if_q[$];
    d_exp_t      d_q[$];
    logic [31:0] mem [0:1023];

    mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, byte-masked write.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[11:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ctl = {if_gnt, d_gnt, ram_en, ram_we, stall}
    task automatic check_cycle(input string name, input logic [7:0] ctl,
                               input logic [31:0] addr, input logic [31:0] wdata);
        check({name, "_ctl"}, {56'd0, if_gnt, d_gnt, ram_en, ram_we, stall}, {56'd0, ctl});
        check({name, "_addr"}, {32'd0, ram_addr}, {32'd0, addr});
        check({name, "_wdata"}, {32'd0, ram_wdata}, {32'd0, wdata});
        $display("[TB] %s: if_gnt=%b d_gnt=%b ram_en=%b ram_we=%b ram_addr=%h ram_wdata=%h stall=%b",
                 name, if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, stall);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {56'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, ram_en, ram_we, stall},
              64'd0);
        check({name, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
        check({name, "_ram"}, {ram_addr, ram_wdata}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
    endtask

    task automatic set_d(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (if_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL if_resp: got unexpected if_rvalid rdata=%h, expected none", if_rdata);
            end else begin
                logic [31:0] e;
                e = if_q.pop_front();
                check("if_rdata", {32'd0, if_rdata}, {32'd0, e});
                $display("[TB] if response rdata=%h", if_rdata);
            end
        end
        if (d_rvalid) begin
            if (d_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL d_resp: got unexpected d_rvalid err=%b rdata=%h, expected none", d_err, d_rdata);
            end else begin
                d_exp_t e;
                e = d_q.pop_front();
                check("d_resp", {31'd0, d_err, d_rdata}, {31'd0, e.err, e.rdata});
                $display("[TB] d response err=%b rdata=%h", d_err, d_rdata);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0BADF00D;
        mem[4]    = 32'h00500093;
        mem[5]    = 32'hDEADBEEF;
        mem['h40] = 32'h11223344;
        mem['h80] = 32'h55667788;
        ram_rdata = 32'h0;

        // Reset with both requests asserted: everything must stay quiet.
        clear();
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        set_d(1'b1, 2'b00, 32'h103, 32'hAB);
        #2;
        check_all_zero("reset");
        step(); step();
        check_all_zero("reset_held");
        clear();
        rst = 1'b1;

        // Fetch only
        step();
        if_req = 1'b1; if_addr = 32'h10;
        #3; check_cycle("fetch", 8'b1_0_1_0000_0, 32'h10, 32'h0);
        if_q.push_back(32'h00500093);
        step(); clear();

        // Store byte at 0x103
        set_d(1'b1, 2'b00, 32'h103, 32'h000000AB);
        #3; check_cycle("st_byte", 8'b0_1_1_1000_0, 32'h100, 32'hABABABAB);
        d_q.push_back('{err: 1'b0, rdata: 32'h0});
        step(); clear();

        // Load word back, sees merged byte
        set_d(1'b0, 2'b10, 32'h100, 32'h0);
        #3; check_cycle("ld_word", 8'b0_1_1_0000_0, 32'h100, 32'h0);
        d_q.push_back('{err: 1'b0, rdata: 32'hAB223344});
        step(); clear();

        // Store half at 0x202
        set_d(1'b1, 2'b01, 32'h202, 32'h1234CDEF);
        #3; check_cycle("st_half", 8'b0_1_1_1100_0, 32'h200, 32'hCDEFCDEF);
        d_q.push_back('{err: 1'b0, rdata: 32'h0});
        step(); clear();

        // Misaligned word load
        set_d(1'b0, 2'b10, 32'h202, 32'h0);
        #3; check_cycle("mis_word", 8'b0_1_0_0000_0, 32'h0, 32'h0);
        d_q.push_back('{err: 1'b1, rdata: 32'h0});
        step(); clear();

        // Illegal size store
        set_d(1'b1, 2'b11, 32'h300, 32'hFFFFFFFF);
        #3; check_cycle("size11", 8'b0_1_0_0000_0, 32'h0, 32'h0);
        d_q.push_back('{err: 1'b1, rdata: 32'h0});
        step(); clear();

        // Misaligned half store
        set_d(1'b1, 2'b01, 32'h201, 32'h5555);
        #3; check_cycle("mis_half", 8'b0_1_0_0000_0, 32'h0, 32'h0);
        d_q.push_back('{err: 1'b1, rdata: 32'h0});
        step(); clear();

        // Byte load at 0x203: raw word reflects the earlier half store
        set_d(1'b0, 2'b00, 32'h203, 32'h0);
        #3; check_cycle("ld_byte", 8'b0_1_1_0000_0, 32'h200, 32'h0);
        d_q.push_back('{err: 1'b0, rdata: 32'hCDEF7788});
        step(); clear();

        // Contention: both request, loser granted next cycle
        if_req = 1'b1; if_addr = 32'h14;
        set_d(1'b0, 2'b10, 32'h0, 32'h0);
`ifdef MEM_ARB_RR_EN
        #3; check_cycle("contend0", 8'b1_0_1_0000_1, 32'h14, 32'h0);
        if_q.push_back(32'hDEADBEEF);
        step(); if_req = 1'b0;
        #3; check_cycle("contend1", 8'b0_1_1_0000_0, 32'h0, 32'h0);
        d_q.push_back('{err: 1'b0, rdata: 32'h0BADF00D});
`else
        #3; check_cycle("contend0", 8'b0_1_1_0000_0, 32'h0, 32'h0);
        d_q.push_back('{err: 1'b0, rdata: 32'h0BADF00D});
        step(); d_req = 1'b0;
        #3; check_cycle("contend1", 8'b1_0_1_0000_0, 32'h14, 32'h0);
        if_q.push_back(32'hDEADBEEF);
`endif
        step(); clear();

        // Back-to-back: fetch then load, responses in consecutive cycles
        step();
        if_req = 1'b1; if_addr = 32'h10;
        #3; check_cycle("b2b_fetch", 8'b1_0_1_0000_0, 32'h10, 32'h0);
        if_q.push_back(32'h00500093);
        step(); clear();
        set_d(1'b0, 2'b10, 32'h100, 32'h0);
        #3; check_cycle("b2b_load", 8'b0_1_1_0000_0, 32'h100, 32'h0);
        check("b2b_rv1", {62'd0, if_rvalid, d_rvalid}, 64'b10);
        d_q.push_back('{err: 1'b0, rdata: 32'hAB223344});
        step(); clear();
        #3; check("b2b_rv2", {62'd0, if_rvalid, d_rvalid}, 64'b01);

        // Reset in the cycle after a grant drops the owed response
        step();
        if_req = 1'b1; if_addr = 32'h10;
        #3; check_cycle("pre_rst", 8'b1_0_1_0000_0, 32'h10, 32'h0);
        step();
        rst = 1'b0;
        #3; check_all_zero("mid_rst");
        step();
        rst = 1'b1;
        #3; check_cycle("post_rst", 8'b1_0_1_0000_0, 32'h10, 32'h0);
        if_q.push_back(32'h00500093);
        step(); clear();

        step(); step(); step();
        check("if_q_drained", {32'd0, 32'(if_q.size())}, 64'd0);
        check("d_q_drained", {32'd0, 32'(d_q.size())}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
